// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Execute-stage forwarding select and load-use stall generator
//            built on an internal DEPTH-entry destination tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int AW    = 3,
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    parameter int SELW  = $clog2(DEPTH + 1),
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC-1:0]      src_used,
    input  logic [AW-1:0]        dst_addr,
    input  logic                 dst_wb,
    input  logic                 dst_is_load,
    input  logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic [CNTW-1:0]      stall_cnt,
    output logic [DEPTH-1:0]     tag_wb
);

    // Index 0 of each tag array is stage 1 (youngest).
    logic [DEPTH-1:0]         r_wb;
    logic [DEPTH-1:0]         r_ld;
    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [CNTW-1:0]          r_cnt;
    logic [NSRC-1:0]          w_load_hit;
    logic                     w_stall;
    logic                     w_accept;

    genvar k;
    generate
        for (k = 0; k < NSRC; k++) begin : g_src
            logic [SELW-1:0] w_sel;

            // Scan oldest to youngest so the youngest match is the final write.
            always_comb begin
                w_sel = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (src_used[k] && r_wb[i] && (r_addr[i] == src_addr[k*AW +: AW])) begin
                        w_sel = SELW'(i + 1);
                    end
                end
            end

            assign fwd_sel[k*SELW +: SELW] = w_sel;
            assign w_load_hit[k]            = (w_sel == SELW'(1)) && r_ld[0];
        end
    endgenerate

    assign w_stall  = issue_valid && !flush && (|w_load_hit);
    assign w_accept = issue_valid && !w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb   <= '0;
            r_ld   <= '0;
            r_addr <= '0;
        end else if (flush) begin
            r_wb <= '0;
            r_ld <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_wb[i]   <= r_wb[i-1];
                r_ld[i]   <= r_ld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
            // A stalled or absent issue enters the pipeline as a bubble.
            r_wb[0]   <= w_accept && dst_wb;
            r_ld[0]   <= w_accept && dst_is_load;
            r_addr[0] <= w_accept ? dst_addr : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall     = w_stall;
    assign stall_cnt = r_cnt;
    assign tag_wb    = r_wb;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Scoreboard bench for fwd_hazard_unit (DEPTH=2/CNTW=2 instance
//            and a NSRC=3/DEPTH=4/AW=5 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int c_sig_a_fwd   = 0;
    localparam int c_sig_a_stall = 1;
    localparam int c_sig_a_cnt   = 2;
    localparam int c_sig_a_tagwb = 3;
    localparam int c_sig_b_fwd   = 4;
    localparam int c_sig_b_tagwb = 5;
    localparam int c_sig_b_stall = 6;

    logic clk;
    logic rst_n;

    logic        a_valid, a_wb, a_ld, a_flush;
    logic [5:0]  a_src;
    logic [1:0]  a_used;
    logic [2:0]  a_dst;
    logic [3:0]  a_fwd;
    logic        a_stall;
    logic [1:0]  a_cnt;
    logic [1:0]  a_tagwb;

    logic        b_valid, b_wb, b_ld, b_flush;
    logic [14:0] b_src;
    logic [2:0]  b_used;
    logic [4:0]  b_dst;
    logic [8:0]  b_fwd;
    logic        b_stall;
    logic [15:0] b_cnt;
    logic [3:0]  b_tagwb;

    fwd_hazard_unit #(.AW(3), .NSRC(2), .DEPTH(2), .CNTW(2)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(a_valid),
        .src_addr   (a_src),
        .src_used   (a_used),
        .dst_addr   (a_dst),
        .dst_wb     (a_wb),
        .dst_is_load(a_ld),
        .flush      (a_flush),
        .fwd_sel    (a_fwd),
        .stall      (a_stall),
        .stall_cnt  (a_cnt),
        .tag_wb     (a_tagwb)
    );

    fwd_hazard_unit #(.AW(5), .NSRC(3), .DEPTH(4), .CNTW(16)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(b_valid),
        .src_addr   (b_src),
        .src_used   (b_used),
        .dst_addr   (b_dst),
        .dst_wb     (b_wb),
        .dst_is_load(b_ld),
        .flush      (b_flush),
        .fwd_sel    (b_fwd),
        .stall      (b_stall),
        .stall_cnt  (b_cnt),
        .tag_wb     (b_tagwb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            c_sig_a_fwd:   return 32'(a_fwd);
            c_sig_a_stall: return 32'(a_stall);
            c_sig_a_cnt:   return 32'(a_cnt);
            c_sig_a_tagwb: return 32'(a_tagwb);
            c_sig_b_fwd:   return 32'(b_fwd);
            c_sig_b_tagwb: return 32'(b_tagwb);
            c_sig_b_stall: return 32'(b_stall);
            default:       return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare_all();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] s1, input logic [2:0] s0,
                           input logic [1:0] used, input logic [2:0] d,
                           input logic wb, input logic ld, input logic fl);
        a_valid = v;
        a_src   = {s1, s0};
        a_used  = used;
        a_dst   = d;
        a_wb    = wb;
        a_ld    = ld;
        a_flush = fl;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] s2, input logic [4:0] s1,
                           input logic [4:0] s0, input logic [2:0] used,
                           input logic [4:0] d, input logic wb);
        b_valid = v;
        b_src   = {s2, s1, s0};
        b_used  = used;
        b_dst   = d;
        b_wb    = wb;
        b_ld    = 1'b0;
        b_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 3'b000, 0, 0);
        #2;
        expect_val("rst_stall", c_sig_a_stall, 0);
        expect_val("rst_fwd",   c_sig_a_fwd,   0);
        expect_val("rst_tagwb", c_sig_a_tagwb, 0);
        expect_val("rst_cnt",   c_sig_a_cnt,   0);
        expect_val("rst_b_tag", c_sig_b_tagwb, 0);
        settle();
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU dependency
        drive_a(1, 0, 0, 2'b00, 3, 1, 0, 0);
        expect_val("b2b_issue_stall", c_sig_a_stall, 0);
        settle(); tick();
        drive_a(1, 0, 3, 2'b01, 0, 0, 0, 0);
        expect_val("b2b_fwd1",   c_sig_a_fwd,   1);
        expect_val("b2b_stall",  c_sig_a_stall, 0);
        expect_val("b2b_tagwb1", c_sig_a_tagwb, 1);
        settle(); tick();
        drive_a(0, 0, 3, 2'b01, 0, 0, 0, 0);
        expect_val("b2b_fwd2",   c_sig_a_fwd,   2);
        expect_val("b2b_tagwb2", c_sig_a_tagwb, 2);
        settle(); tick();
        expect_val("b2b_fwd0",   c_sig_a_fwd,   0);
        expect_val("b2b_tagwb0", c_sig_a_tagwb, 0);
        settle(); tick();

        // Youngest stage wins
        drive_a(1, 0, 0, 2'b00, 5, 1, 0, 0); tick();
        drive_a(1, 0, 0, 2'b00, 5, 1, 0, 0); tick();
        drive_a(1, 5, 5, 2'b11, 0, 0, 0, 0);
        expect_val("prio_fwd",   c_sig_a_fwd,   4'b0101);
        expect_val("prio_stall", c_sig_a_stall, 0);
        expect_val("prio_tagwb", c_sig_a_tagwb, 2'b11);
        settle(); tick();
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0); tick(); tick();

        // Load-use
        drive_a(1, 0, 0, 2'b00, 2, 1, 1, 0);
        expect_val("lu_load_stall", c_sig_a_stall, 0);
        settle(); tick();
        drive_a(1, 0, 2, 2'b01, 7, 1, 0, 0);
        expect_val("lu_fwd1",  c_sig_a_fwd,   1);
        expect_val("lu_stall", c_sig_a_stall, 1);
        expect_val("lu_cnt0",  c_sig_a_cnt,   0);
        settle(); tick();
        expect_val("lu_retry_fwd",   c_sig_a_fwd,   2);
        expect_val("lu_retry_stall", c_sig_a_stall, 0);
        expect_val("lu_cnt1",        c_sig_a_cnt,   1);
        expect_val("lu_tagwb",       c_sig_a_tagwb, 2'b10);
        settle(); tick();

        // Flush with issue
        drive_a(1, 0, 0, 2'b00, 1, 1, 0, 0); tick();
        drive_a(1, 0, 0, 2'b00, 4, 1, 0, 0); tick();
        drive_a(1, 4, 1, 2'b11, 6, 1, 0, 1);
        expect_val("fl_fwd_same_cycle", c_sig_a_fwd,   4'b0110);
        expect_val("fl_stall",          c_sig_a_stall, 0);
        settle(); tick();
        drive_a(0, 4, 1, 2'b11, 0, 0, 0, 0);
        expect_val("fl_fwd_r1_r4", c_sig_a_fwd,   0);
        expect_val("fl_tagwb",     c_sig_a_tagwb, 0);
        settle(); tick();
        drive_a(0, 6, 6, 2'b11, 0, 0, 0, 0);
        expect_val("fl_fwd_r6", c_sig_a_fwd, 0);
        settle(); tick();

        // Flush suppresses a load-use stall and its count
        drive_a(1, 0, 0, 2'b00, 3, 1, 1, 0); tick();
        drive_a(1, 0, 3, 2'b01, 0, 0, 0, 1);
        expect_val("fl_lu_fwd",   c_sig_a_fwd,   1);
        expect_val("fl_lu_stall", c_sig_a_stall, 0);
        settle(); tick();
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        expect_val("fl_lu_cnt",   c_sig_a_cnt,   1);
        expect_val("fl_lu_tagwb", c_sig_a_tagwb, 0);
        settle(); tick();

        // Counter saturation at 2 bits
        for (int i = 0; i < 5; i++) begin
            drive_a(1, 0, 0, 2'b00, 2, 1, 1, 0); tick();
            drive_a(1, 0, 2, 2'b01, 0, 0, 0, 0);
            expect_val($sformatf("sat_stall%0d", i), c_sig_a_stall, 1);
            expect_val($sformatf("sat_cnt%0d", i),   c_sig_a_cnt,   (i + 1 > 3) ? 3 : i + 1);
            settle(); tick();
            expect_val($sformatf("sat_retry_fwd%0d", i), c_sig_a_fwd,   2);
            expect_val($sformatf("sat_retry_stl%0d", i), c_sig_a_stall, 0);
            settle(); tick();
        end
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        expect_val("sat_hold", c_sig_a_cnt, 3);
        settle(); tick();

        // Asynchronous reset mid-cycle
        drive_a(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
        drive_a(1, 5, 5, 2'b11, 0, 0, 0, 0);
        expect_val("arst_pre_stall", c_sig_a_stall, 1);
        expect_val("arst_pre_fwd",   c_sig_a_fwd,   4'b0101);
        settle();
        rst_n = 1'b0;
        #1;
        expect_val("arst_stall", c_sig_a_stall, 0);
        expect_val("arst_fwd",   c_sig_a_fwd,   0);
        expect_val("arst_tagwb", c_sig_a_tagwb, 0);
        expect_val("arst_cnt",   c_sig_a_cnt,   0);
        compare_all();
        drive_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Wide instance: NSRC=3, DEPTH=4, AW=5
        drive_b(1, 0, 0, 0, 3'b000, 17, 1); tick();
        drive_b(1, 0, 0, 0, 3'b000, 9,  1); tick();
        drive_b(1, 0, 0, 0, 3'b000, 30, 1); tick();
        drive_b(1, 0, 0, 0, 3'b000, 0,  1); tick();
        drive_b(0, 30, 9, 17, 3'b111, 0, 0);
        expect_val("wide_fwd",   c_sig_b_fwd,   (2 << 6) | (3 << 3) | 4);
        expect_val("wide_tagwb", c_sig_b_tagwb, 4'b1111);
        expect_val("wide_stall", c_sig_b_stall, 0);
        settle();
        b_used = 3'b101;
        expect_val("wide_unused_op1", c_sig_b_fwd, (2 << 6) | 4);
        settle();
        drive_b(0, 30, 9, 0, 3'b111, 0, 0);
        expect_val("wide_r0", c_sig_b_fwd, (2 << 6) | (3 << 3) | 1);
        settle(); tick();
        drive_b(0, 30, 9, 17, 3'b111, 0, 0);
        expect_val("wide_aged_fwd",   c_sig_b_fwd,   (3 << 6) | (4 << 3) | 0);
        expect_val("wide_aged_tagwb", c_sig_b_tagwb, 4'b1110);
        settle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
